// File: rtl/vector_unit_param_if.sv
// -----------------------------------------------------------------------------
// vector_unit_param_if
//   Bundles the signals between the vector unit and whoever drives it.
//   - Instruction handshake: instr_valid/instr_ready/instruction, plus the
//     done/err retirement pulses and the busy status flag.
//   - Debug port: dbg_sel selects a register, dbg_data shows its contents.
//   - External memory port: ext_we/ext_addr/ext_wdata for preloading, and
//     ext_rdata (registered, one cycle after ext_addr) for inspection.
//   Modports: slave is the vector unit side, master is the driver side.
// -----------------------------------------------------------------------------
interface vector_unit_param_if #(
   parameter int LANES     = 16,
   parameter int ELEM_W    = 32,
   parameter int NUM_REGS  = 4,
   parameter int MEM_DEPTH = 512
);
   localparam int RSW = $clog2(NUM_REGS);
   localparam int AW  = $clog2(MEM_DEPTH);
   localparam int IW  = 3 + 3*RSW + AW;
   localparam int VW  = LANES*ELEM_W;

   logic            instr_valid;
   logic            instr_ready;
   logic [IW-1:0]   instruction;
   logic            done;
   logic            err;
   logic            busy;
   logic [RSW-1:0]  dbg_sel;
   logic [VW-1:0]   dbg_data;
   logic            ext_we;
   logic [AW-1:0]   ext_addr;
   logic [VW-1:0]   ext_wdata;
   logic [VW-1:0]   ext_rdata;

   modport slave (
      input  instr_valid, instruction, dbg_sel, ext_we, ext_addr, ext_wdata,
      output instr_ready, done, err, busy, dbg_data, ext_rdata
   );

   modport master (
      output instr_valid, instruction, dbg_sel, ext_we, ext_addr, ext_wdata,
      input  instr_ready, done, err, busy, dbg_data, ext_rdata
   );
endinterface

// File: rtl/vector_unit_param.sv
// -----------------------------------------------------------------------------
// vector_unit_param
//   Parametrised SIMD vector unit with its own register file and data memory.
//   Each instruction goes IDLE -> EXEC -> WB -> IDLE, so one instruction is
//   retired every three cycles with a done pulse during WB.
//   Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 MUL (lo->rd, hi->rd+1),
//            100 SUB, 101 ADDS (signed saturating), 110/111 illegal (err).
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-low
//   bus   - vector_unit_param_if.slave (instruction handshake, retirement
//           pulses, busy, debug register view, external memory port)
// -----------------------------------------------------------------------------
module vector_unit_param #(
   parameter int  LANES     = 16,
   parameter int  ELEM_W    = 32,
   parameter int  NUM_REGS  = 4,
   parameter int  MEM_DEPTH = 512,
   localparam int RSW       = $clog2(NUM_REGS),
   localparam int AW        = $clog2(MEM_DEPTH),
   localparam int IW        = 3 + 3*RSW + AW
) (
   input  logic               clk,
   input  logic               reset,
   vector_unit_param_if.slave bus
);
   localparam int VW = LANES*ELEM_W;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_MUL   = 3'b011;
   localparam logic [2:0] OP_SUB   = 3'b100;
   localparam logic [2:0] OP_ADDS  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Control state
   state_t          state_q, state_d;
   logic [IW-1:0]   instr_q, instr_d;
   logic            ready_q, ready_d;
   logic            busy_q,  busy_d;
   logic            done_q,  done_d;
   logic            err_q,   err_d;

   // Results computed in EXEC, written into the register file in WB
   logic [VW-1:0]   res_lo_q, res_lo_d;
   logic [VW-1:0]   res_hi_q, res_hi_d;
   logic            wr_lo_q, wr_lo_d;
   logic            wr_hi_q, wr_hi_d;
   logic            wr_ld_q, wr_ld_d;

   // Register file is reset to zero, so it lives in flops
   logic [VW-1:0]   rf_q [NUM_REGS];
   logic [VW-1:0]   rf_d [NUM_REGS];

   // Data memory: not reset, registered reads
   logic [VW-1:0]   mem [MEM_DEPTH];
   logic [VW-1:0]   load_rdata_q;
   logic [VW-1:0]   ext_rdata_q;
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [VW-1:0]   mem_wdata;

   // Instruction field decode from the latched instruction
   logic [2:0]      op;
   logic [RSW-1:0]  rd, rd_hi, rs1, rs2;
   logic [AW-1:0]   addr;

   assign op    = instr_q[IW-1 -: 3];
   assign rd    = instr_q[IW-4 -: RSW];
   assign rs1   = instr_q[IW-4-RSW -: RSW];
   assign rs2   = instr_q[IW-4-2*RSW -: RSW];
   assign addr  = instr_q[AW-1:0];
   // NUM_REGS is a power of two, so the natural wrap of RSW bits gives mod
   assign rd_hi = rd + RSW'(1);

   // Lane-wise datapath
   logic [VW-1:0]   opa, opb;
   logic [VW-1:0]   add_v, sub_v, adds_v, mul_lo_v, mul_hi_v;

   assign opa = rf_q[rs1];
   assign opb = rf_q[rs2];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [ELEM_W-1:0]   a, b, sum;
         logic [2*ELEM_W-1:0] prod;
         logic                ovf;

         assign a   = opa[gi*ELEM_W +: ELEM_W];
         assign b   = opb[gi*ELEM_W +: ELEM_W];
         assign sum = a + b;

         // Sign-extending both operands to 2*ELEM_W makes the unsigned
         // product's low 2*ELEM_W bits equal to the signed product.
         assign prod = {{ELEM_W{a[ELEM_W-1]}}, a} * {{ELEM_W{b[ELEM_W-1]}}, b};

         // Overflow only when both inputs share a sign the sum does not have;
         // the clamp direction follows the input sign.
         assign ovf = (a[ELEM_W-1] == b[ELEM_W-1]) && (sum[ELEM_W-1] != a[ELEM_W-1]);

         assign add_v[gi*ELEM_W +: ELEM_W]    = sum;
         assign sub_v[gi*ELEM_W +: ELEM_W]    = a - b;
         assign adds_v[gi*ELEM_W +: ELEM_W]   = !ovf ? sum :
                                                (a[ELEM_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}}
                                                             : {1'b0, {(ELEM_W-1){1'b1}}});
         assign mul_lo_v[gi*ELEM_W +: ELEM_W] = prod[ELEM_W-1:0];
         assign mul_hi_v[gi*ELEM_W +: ELEM_W] = prod[2*ELEM_W-1:ELEM_W];
      end
   endgenerate

   // Next-state and register-file update
   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      ready_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      wr_lo_d  = wr_lo_q;
      wr_hi_d  = wr_hi_q;
      wr_ld_d  = wr_ld_q;
      rf_d     = rf_q;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            if (bus.instr_valid && ready_q) begin
               instr_d = bus.instruction;
               state_d = S_EXEC;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_EXEC: begin
            state_d = S_WB;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            wr_lo_d = 1'b0;
            wr_hi_d = 1'b0;
            wr_ld_d = 1'b0;
            case (op)
               OP_LOAD:  wr_ld_d = 1'b1;
               OP_STORE: wr_lo_d = 1'b0;
               OP_ADD: begin
                  res_lo_d = add_v;
                  wr_lo_d  = 1'b1;
               end
               OP_MUL: begin
                  res_lo_d = mul_lo_v;
                  res_hi_d = mul_hi_v;
                  wr_lo_d  = 1'b1;
                  wr_hi_d  = 1'b1;
               end
               OP_SUB: begin
                  res_lo_d = sub_v;
                  wr_lo_d  = 1'b1;
               end
               OP_ADDS: begin
                  res_lo_d = adds_v;
                  wr_lo_d  = 1'b1;
               end
               default: err_d = 1'b1;
            endcase
         end

         S_WB: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            if (wr_ld_q) rf_d[rd]    = load_rdata_q;
            if (wr_lo_q) rf_d[rd]    = res_lo_q;
            if (wr_hi_q) rf_d[rd_hi] = res_hi_q;
         end

         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         wr_lo_q  <= 1'b0;
         wr_hi_q  <= 1'b0;
         wr_ld_q  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         wr_lo_q  <= wr_lo_d;
         wr_hi_q  <= wr_hi_d;
         wr_ld_q  <= wr_ld_d;
         rf_q     <= rf_d;
      end
   end

   // Single memory write port: external writes only while idle, STORE commits
   // on the EXEC->WB edge. The two never overlap. Reset blocks both so an
   // aborted STORE leaves memory untouched.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.ext_addr;
      mem_wdata = bus.ext_wdata;
      if (state_q == S_IDLE && bus.ext_we) begin
         mem_we = 1'b1;
      end else if (state_q == S_EXEC && op == OP_STORE) begin
         mem_we    = 1'b1;
         mem_waddr = addr;
         mem_wdata = opa;
      end
      if (!reset) begin
         mem_we = 1'b0;
      end
   end

   // Read ports sample the pre-write contents on a write edge
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      load_rdata_q <= mem[addr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ext_rdata_q <= '0;
      end else begin
         ext_rdata_q <= mem[bus.ext_addr];
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.busy        = busy_q;
   assign bus.dbg_data    = rf_q[bus.dbg_sel];
   assign bus.ext_rdata   = ext_rdata_q;

endmodule
